// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver, 16x oversampling, first-word-fall-through receive FIFO
//
// Purpose:
//   Deserialises frames on data_in at one of four baud rates. Bits are sampled at their centre,
//   LSB first. Good bytes are pushed into a FWFT FIFO that the host drains with read_enable.
//   Framing, overrun and parity problems are reported as one-clock pulses.
//   Optional feature macro: UART_RECEIVER_PARITY_EN. When defined, an even parity bit is
//   expected between the data bits and the stop bit.
//
// Ports:
//   clock                - system clock, rising edge
//   reset                - asynchronous, active-high reset
//   data_in              - serial line, idle high, asynchronous to clock
//   read_enable          - pops the FIFO head when the FIFO is not empty
//   buffer_threshold     - level compare value for buffer_level_reached
//   baudrate_select      - 00 = 9600, 01 = 19200, 10 = 57600, 11 = 115200
//   data_out             - FIFO head, valid while buffer_empty is 0
//   buffer_empty         - FIFO holds no entries
//   buffer_level_reached - FIFO count >= buffer_threshold
//   frame_error          - pulse: stop bit sampled 0
//   overrun              - pulse: good byte dropped because the FIFO was full
//   parity_error         - pulse: parity mismatch (tied 0 without the parity feature)
module uart_receiver #(
   parameter int CLOCK_FREQUENCY = 50_000_000,
   parameter int FIFO_DEPTH      = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       data_in,
   input  logic       read_enable,
   input  logic [5:0] buffer_threshold,
   input  logic [1:0] baudrate_select,
   output logic [7:0] data_out,
   output logic       buffer_empty,
   output logic       buffer_level_reached,
   output logic       frame_error,
   output logic       overrun,
   output logic       parity_error
);
   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam int CW        = AW + 1;
   localparam int DIV_9600  = CLOCK_FREQUENCY / (16 * 9600) - 1;
   localparam int DIV_19200 = CLOCK_FREQUENCY / (16 * 19200) - 1;
   localparam int DIV_57600 = CLOCK_FREQUENCY / (16 * 57600) - 1;
   localparam int DIV_115K  = CLOCK_FREQUENCY / (16 * 115200) - 1;
   // The slowest rate has the largest divisor, so it sizes the tick counter.
   localparam int TW        = (DIV_9600 > 0) ? $clog2(DIV_9600 + 1) : 1;

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      START,
      DATA,
`ifdef UART_RECEIVER_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     sync_q, sync_d;
   logic           line_prev_q, line_prev_d;
   logic [1:0]     baud_q, baud_d;
   logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
   logic [3:0]     os_cnt_q, os_cnt_d;
   logic [2:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]     shift_q, shift_d;
   logic           discard_q, discard_d;
   logic           frame_error_q, frame_error_d;
   logic           overrun_q, overrun_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [7:0]     mem [FIFO_DEPTH];

   logic           line;
   logic           tick;
   logic [TW-1:0]  divisor;
   logic           push_req;
   logic           push;
   logic           pop;
   logic           full;

   assign line = sync_q[1];

   always_comb begin
      case (baud_q)
         2'd0:    divisor = TW'(DIV_9600);
         2'd1:    divisor = TW'(DIV_19200);
         2'd2:    divisor = TW'(DIV_57600);
         default: divisor = TW'(DIV_115K);
      endcase
   end

   assign tick = (tick_cnt_q == divisor);

`ifdef UART_RECEIVER_PARITY_EN
   logic parity_error_q, parity_error_d;
   assign parity_error = parity_error_q;
`else
   assign parity_error = 1'b0;
`endif

   // Receive state machine, synchroniser and oversampling counters.
   always_comb begin
      state_d       = state_q;
      sync_d        = {sync_q[0], data_in};
      line_prev_d   = line;
      baud_d        = baud_q;
      tick_cnt_d    = tick ? '0 : tick_cnt_q + TW'(1);
      os_cnt_d      = os_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      discard_d     = discard_q;
      push_req      = 1'b0;
      frame_error_d = 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
      parity_error_d = 1'b0;
`endif
      if (state_q != WAIT_IDLE && state_q != IDLE && tick) begin
         os_cnt_d = os_cnt_q + 4'd1;
      end
      case (state_q)
         WAIT_IDLE: begin
            if (line) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            // Start edge: realign the tick phase and freeze the rate for this frame.
            if (line_prev_q && !line) begin
               state_d    = START;
               baud_d     = baudrate_select;
               tick_cnt_d = '0;
               os_cnt_d   = '0;
               bit_cnt_d  = '0;
               discard_d  = 1'b0;
            end
         end
         START: begin
            // The 8th tick is the start-bit centre; later bits are 16 ticks apart.
            if (tick && os_cnt_q == 4'd7) begin
               os_cnt_d = '0;
               state_d  = line ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tick && os_cnt_q == 4'd15) begin
               shift_d   = {line, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
`ifdef UART_RECEIVER_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_RECEIVER_PARITY_EN
         PARITY: begin
            if (tick && os_cnt_q == 4'd15) begin
               if (line != ^shift_q) begin
                  parity_error_d = 1'b1;
                  discard_d      = 1'b1;
               end
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            // Leave at the stop-bit centre so a back-to-back start edge is not missed.
            if (tick && os_cnt_q == 4'd15) begin
               if (line) begin
                  push_req = !discard_q;
                  state_d  = IDLE;
               end else begin
                  frame_error_d = 1'b1;
                  state_d       = WAIT_IDLE;
               end
            end
         end
         default: state_d = WAIT_IDLE;
      endcase
   end

   // FIFO bookkeeping. A push into a full FIFO only succeeds if a pop frees a slot this cycle.
   assign buffer_empty         = (count_q == '0);
   assign full                 = (count_q == CW'(FIFO_DEPTH));
   assign pop                  = read_enable && !buffer_empty;
   assign push                 = push_req && (!full || pop);
   assign data_out             = buffer_empty ? 8'h00 : mem[rd_ptr_q];
   assign buffer_level_reached = (32'(count_q) >= 32'(buffer_threshold));
   assign frame_error          = frame_error_q;
   assign overrun              = overrun_q;

   always_comb begin
      overrun_d = push_req && full && !pop;
      wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d   = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr_q] <= shift_q;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= WAIT_IDLE;
         sync_q        <= 2'b11;
         line_prev_q   <= 1'b1;
         baud_q        <= 2'd0;
         tick_cnt_q    <= '0;
         os_cnt_q      <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         discard_q     <= 1'b0;
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
`ifdef UART_RECEIVER_PARITY_EN
         parity_error_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         sync_q        <= sync_d;
         line_prev_q   <= line_prev_d;
         baud_q        <= baud_d;
         tick_cnt_q    <= tick_cnt_d;
         os_cnt_q      <= os_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         discard_q     <= discard_d;
         frame_error_q <= frame_error_d;
         overrun_q     <= overrun_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
`ifdef UART_RECEIVER_PARITY_EN
         parity_error_q <= parity_error_d;
`endif
      end
   end
endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed table-driven bench for uart_receiver
module tb_uart_receiver;
   localparam int CF    = 3_686_400;
   localparam int DEPTH = 64;
`ifdef UART_RECEIVER_PARITY_EN
   localparam int NB = 10;
`else
   localparam int NB = 9;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       data_in = 1'b1;
   logic       read_enable = 1'b0;
   logic [5:0] buffer_threshold = 6'd0;
   logic [1:0] baudrate_select = 2'd3;
   logic [7:0] data_out;
   logic       buffer_empty;
   logic       buffer_level_reached;
   logic       frame_error;
   logic       overrun;
   logic       parity_error;

   uart_receiver #(.CLOCK_FREQUENCY(CF), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock),
      .reset(reset),
      .data_in(data_in),
      .read_enable(read_enable),
      .buffer_threshold(buffer_threshold),
      .baudrate_select(baudrate_select),
      .data_out(data_out),
      .buffer_empty(buffer_empty),
      .buffer_level_reached(buffer_level_reached),
      .frame_error(frame_error),
      .overrun(overrun),
      .parity_error(parity_error)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int pe_cnt = 0;

   logic pre_empty, post_empty, pre_fe, post_fe;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       par_flip;
      logic [1:0] baud;
      logic [1:0] mid_baud;
      logic       exp_push;
      logic       exp_fe;
      logic       exp_pe;
   } vec_t;

   vec_t vecs[$];

   always @(negedge clock) begin
      if (frame_error === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (parity_error === 1'b1) pe_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Clocks per oversample tick for each rate.
   function automatic int dvals(input logic [1:0] b);
      case (b)
         2'd0:    return CF / (16 * 9600);
         2'd1:    return CF / (16 * 19200);
         2'd2:    return CF / (16 * 57600);
         default: return CF / (16 * 115200);
      endcase
   endfunction

   // Drives one frame starting at the current negedge. Samples buffer_empty and frame_error on
   // the negedges just before and just after the expected stop-centre update.
   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                             input logic [1:0] b, input logic [1:0] mid_b, input int idle_bits);
      int dd;
      int centre;
      logic [10:0] bits;
      dd = dvals(b);
      centre = 8 * dd + 16 * NB * dd;
      bits = 11'h7FF;
      bits[0] = 1'b0;
      bits[8:1] = d;
      if (NB == 10) begin
         bits[9] = par_b;
         bits[10] = stop_b;
      end else begin
         bits[9] = stop_b;
      end
      baudrate_select = b;
      for (int n = 0; n < (NB + 1) * 16 * dd; n++) begin
         if (n == centre + 2) begin
            pre_empty = buffer_empty;
            pre_fe = frame_error;
         end
         if (n == centre + 3) begin
            post_empty = buffer_empty;
            post_fe = frame_error;
         end
         if (n == 4) baudrate_select = mid_b;
         data_in = bits[n / (16 * dd)];
         @(negedge clock);
      end
      data_in = 1'b1;
      repeat (idle_bits * 16 * dd) @(negedge clock);
   endtask

   task automatic pop_one();
      read_enable = 1'b1;
      @(negedge clock);
      read_enable = 1'b0;
   endtask

   initial begin
      int fe0, ov0, pe0, cnt;
      int dd;
      logic [10:0] bits;

      vecs.push_back('{8'hA5, 1'b1, 1'b0, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{8'h3C, 1'b0, 1'b0, 2'd3, 2'd3, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{8'h3C, 1'b1, 1'b0, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{8'h5A, 1'b1, 1'b0, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{8'hC3, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{8'h01, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{8'hFF, 1'b0, 1'b0, 2'd2, 2'd2, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{8'h80, 1'b1, 1'b0, 2'd3, 2'd1, 1'b1, 1'b0, 1'b0});
`ifdef UART_RECEIVER_PARITY_EN
      vecs.push_back('{8'h07, 1'b1, 1'b1, 2'd3, 2'd3, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{8'h07, 1'b1, 1'b0, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0});
`endif

      // Reset state
      #2 reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check("rst_empty", 32'(buffer_empty), 32'd1);
      check("rst_data_out", 32'(data_out), 32'h00);
      check("rst_frame_error", 32'(frame_error), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_parity_error", 32'(parity_error), 32'd0);
      check("rst_level_thr0", 32'(buffer_level_reached), 32'd1);
      buffer_threshold = 6'd1;
      #1;
      check("rst_level_thr1", 32'(buffer_level_reached), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      repeat (8) @(negedge clock);

      // Table of single frames
      foreach (vecs[i]) begin
         fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
         send_frame(vecs[i].data, vecs[i].stop, (^vecs[i].data) ^ vecs[i].par_flip,
                    vecs[i].baud, vecs[i].mid_baud, 2);
         check($sformatf("v%0d_fe_pulses", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
         check($sformatf("v%0d_pe_pulses", i), 32'(pe_cnt - pe0), 32'(vecs[i].exp_pe));
         check($sformatf("v%0d_ov_pulses", i), 32'(ov_cnt - ov0), 32'd0);
         if (vecs[i].exp_push) begin
            check($sformatf("v%0d_empty_before_push", i), 32'(pre_empty), 32'd1);
            check($sformatf("v%0d_empty_after_push", i), 32'(post_empty), 32'd0);
            check($sformatf("v%0d_empty", i), 32'(buffer_empty), 32'd0);
            check($sformatf("v%0d_data_out", i), 32'(data_out), 32'(vecs[i].data));
            pop_one();
            check($sformatf("v%0d_empty_after_pop", i), 32'(buffer_empty), 32'd1);
         end else begin
            check($sformatf("v%0d_no_push", i), 32'(buffer_empty), 32'd1);
         end
         if (vecs[i].exp_fe) begin
            check($sformatf("v%0d_fe_before", i), 32'(pre_fe), 32'd0);
            check($sformatf("v%0d_fe_after", i), 32'(post_fe), 32'd1);
         end
      end

      // False start: low for 4 ticks then high
      fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
      baudrate_select = 2'd3;
      dd = dvals(2'd3);
      data_in = 1'b0;
      repeat (4 * dd) @(negedge clock);
      data_in = 1'b1;
      repeat (32 * dd) @(negedge clock);
      check("false_start_empty", 32'(buffer_empty), 32'd1);
      check("false_start_flags", 32'(fe_cnt - fe0 + pe_cnt - pe0 + ov_cnt - ov0), 32'd0);
      send_frame(8'h00, 1'b1, 1'b0, 2'd3, 2'd3, 2);
      check("after_false_start_empty", 32'(buffer_empty), 32'd0);
      check("after_false_start_data", 32'(data_out), 32'h00);
      pop_one();

      // Fill and overrun, frames back to back
      buffer_threshold = 6'd63;
      ov0 = ov_cnt;
      for (int i = 0; i < 65; i++) begin
         send_frame(8'(i), 1'b1, ^(8'(i)), 2'd3, 2'd3, 0);
         cnt = (i + 1 > DEPTH) ? DEPTH : i + 1;
         check($sformatf("fill%0d_level", i), 32'(buffer_level_reached), 32'(cnt >= 63));
         check($sformatf("fill%0d_overrun", i), 32'(ov_cnt - ov0), 32'(i == 64));
      end
      repeat (4) @(negedge clock);
      for (int i = 0; i < 64; i++) begin
         check($sformatf("read%0d_empty", i), 32'(buffer_empty), 32'd0);
         check($sformatf("read%0d_data", i), 32'(data_out), 32'(i));
         pop_one();
      end
      check("drained_empty", 32'(buffer_empty), 32'd1);
      check("drained_level", 32'(buffer_level_reached), 32'd0);
      pop_one();
      check("pop_on_empty_empty", 32'(buffer_empty), 32'd1);
      check("pop_on_empty_data", 32'(data_out), 32'h00);
      buffer_threshold = 6'd0;

      // Reset during data bit 4 of 0xFF, with a stale byte already queued
      send_frame(8'h55, 1'b1, ^8'h55, 2'd3, 2'd3, 1);
      check("stale_byte_queued", 32'(buffer_empty), 32'd0);
      dd = dvals(2'd3);
      bits = 11'h7FF;
      bits[0] = 1'b0;
      for (int n = 0; n < (NB + 1) * 16 * dd; n++) begin
         if (n == 5 * 16 * dd + 8 * dd) reset = 1'b1;
         if (n == 5 * 16 * dd + 8 * dd + 2) reset = 1'b0;
         data_in = bits[n / (16 * dd)];
         @(negedge clock);
      end
      data_in = 1'b1;
      repeat (32 * dd) @(negedge clock);
      check("reset_flushed_empty", 32'(buffer_empty), 32'd1);
      check("reset_flushed_data", 32'(data_out), 32'h00);
      send_frame(8'h81, 1'b1, ^8'h81, 2'd3, 2'd3, 2);
      check("post_reset_empty", 32'(buffer_empty), 32'd0);
      check("post_reset_data", 32'(data_out), 32'h81);
      pop_one();
      check("post_reset_only_one", 32'(buffer_empty), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
